branch_target_buffer: RTL and testbench

- Sits directly upstream of the fetch stage.
- Each cycle it looks up the current fetch PC and drives the next-PC prediction (pc_prediction) into the fetch interface.
- Direct-mapped BTB with one 2-bit saturating direction counter per entry.
- Trained by branch/jump resolution from the execute stage; the same resolution also drives misprediction and correct_pc into fetch.

---
 rtl/isa_pkg.sv | 30 +++
 rtl/sat_counter2.sv | 37 +++
 rtl/branch_target_buffer.sv | 87 ++++++++
 tb/tb_branch_target_buffer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | isa_pkg: shared ISA-level types (word, BTB entry, direction counter).    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package isa_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_t;

  localparam int BTB_ENTRIES_DEFAULT = 16;

  // Sized for the smallest legal table (2 entries); larger tables zero-pad the top.
  localparam int BTB_TAG_FIELD_W = 29;

  typedef struct packed {
    logic                       valid;
    logic [BTB_TAG_FIELD_W-1:0] tag;
    word_t                      target;
    bp_cnt_t                    cnt;
  } btb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_counter2: next-state function of a 2-bit saturating direction ctr.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sat_counter2
  import isa_pkg::*;
(
  input  bp_cnt_t i_cnt,
  input  logic    i_taken,
  input  logic    i_force,
  output bp_cnt_t o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_force) begin
      o_cnt = ST;
    end else if (i_taken) begin
      case (i_cnt)
        SNT:     o_cnt = WNT;
        WNT:     o_cnt = WT;
        WT:      o_cnt = ST;
        default: o_cnt = ST;
      endcase
    end else begin
      case (i_cnt)
        ST:      o_cnt = WT;
        WT:      o_cnt = WNT;
        WNT:     o_cnt = SNT;
        default: o_cnt = SNT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_target_buffer: direct-mapped BTB with 2-bit direction counters.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module branch_target_buffer
  import isa_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES_DEFAULT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t pc,
  output word_t pc_prediction,
  output logic  pred_taken,
  output logic  pred_hit,
  input  logic  upd_en,
  input  word_t upd_pc,
  input  word_t upd_target,
  input  logic  upd_taken,
  input  logic  upd_is_jump
);

  localparam int IDX_W    = $clog2(ENTRIES);
  localparam int TAG_W    = 30 - IDX_W;
  localparam int C_PAD_W  = BTB_TAG_FIELD_W - TAG_W;
  localparam word_t C_PC_INC = 32'd4;

  btb_entry_t r_table [ENTRIES];

  logic [IDX_W-1:0]           w_idx;
  logic [BTB_TAG_FIELD_W-1:0] w_tag;
  btb_entry_t                 w_rd;

  logic [IDX_W-1:0]           w_upd_idx;
  logic [BTB_TAG_FIELD_W-1:0] w_upd_tag;
  btb_entry_t                 w_upd_rd;
  logic                       w_upd_hit;
  bp_cnt_t                    w_next_cnt;

  logic                       w_unused;

  assign w_unused = ^{pc[1:0], upd_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign w_idx = pc[IDX_W+1:2];
  assign w_tag = {{C_PAD_W{1'b0}}, pc[31:IDX_W+2]};
  assign w_rd  = r_table[w_idx];

  assign pred_hit      = w_rd.valid && (w_rd.tag == w_tag);
  assign pred_taken    = pred_hit && w_rd.cnt[1];
  assign pc_prediction = pred_taken ? w_rd.target : (pc + C_PC_INC);

  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = {{C_PAD_W{1'b0}}, upd_pc[31:IDX_W+2]};
  assign w_upd_rd  = r_table[w_upd_idx];
  assign w_upd_hit = w_upd_rd.valid && (w_upd_rd.tag == w_upd_tag);

  sat_counter2 u_cnt (
    .i_cnt   (w_upd_rd.cnt),
    .i_taken (upd_taken),
    .i_force (upd_is_jump),
    .o_cnt   (w_next_cnt)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i].valid <= 1'b0;
        r_table[i].cnt   <= WNT;
      end
    end else if (upd_en) begin
      if (w_upd_hit) begin
        r_table[w_upd_idx].target <= upd_target;
        r_table[w_upd_idx].cnt    <= w_next_cnt;
      end else if (upd_taken || upd_is_jump) begin
        // Not-taken misses never allocate, keeping cold branches out of the table.
        r_table[w_upd_idx].valid  <= 1'b1;
        r_table[w_upd_idx].tag    <= w_upd_tag;
        r_table[w_upd_idx].target <= upd_target;
        r_table[w_upd_idx].cnt    <= upd_is_jump ? ST : WT;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_branch_target_buffer: directed + random checks against a table model.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_branch_target_buffer;

  localparam int N = 16;

  logic        CLK;
  logic        nRST;
  logic [31:0] pc;
  logic [31:0] pc_prediction;
  logic        pred_taken;
  logic        pred_hit;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_is_jump;

  int n_cmp;
  int n_bad;

  bit          m_valid  [N];
  logic [31:0] m_tag    [N];
  logic [31:0] m_target [N];
  int          m_cnt    [N];

  branch_target_buffer #(.ENTRIES(N)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .pc            (pc),
    .pc_prediction (pc_prediction),
    .pred_taken    (pred_taken),
    .pred_hit      (pred_hit),
    .upd_en        (upd_en),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_taken     (upd_taken),
    .upd_is_jump   (upd_is_jump)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % N);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * N);
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
  endtask

  // Drives one cycle's inputs and checks the lookup at the following falling edge.
  task automatic drive(input logic rn, input logic [31:0] p, input logic en,
                       input logic [31:0] up, input logic [31:0] ut,
                       input logic tk, input logic jp, input string name);
    int          i;
    logic        eh;
    logic        et;
    logic [31:0] ep;
    nRST = rn; pc = p; upd_en = en; upd_pc = up; upd_target = ut;
    upd_taken = tk; upd_is_jump = jp;
    @(negedge CLK);
    i  = idx_of(p);
    eh = m_valid[i] && (m_tag[i] == tag_of(p));
    et = eh && (m_cnt[i] >= 2);
    ep = et ? m_target[i] : p + 32'd4;
    check({name, "_hit"},   {31'd0, pred_hit},   {31'd0, eh});
    check({name, "_taken"}, {31'd0, pred_taken}, {31'd0, et});
    check({name, "_pred"},  pc_prediction,       ep);
  endtask

  task automatic tick();
    int i;
    @(posedge CLK);
    if (!nRST) begin
      model_reset();
    end else if (upd_en) begin
      i = idx_of(upd_pc);
      if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
        m_target[i] = upd_target;
        if (upd_is_jump)    m_cnt[i] = 3;
        else if (upd_taken) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
        else                m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
      end else if (upd_taken || upd_is_jump) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(upd_pc);
        m_target[i] = upd_target;
        m_cnt[i]    = upd_is_jump ? 3 : 2;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] t;
    case ($urandom_range(0, 2))
      0:       t = 32'h0;
      1:       t = 32'h1;
      default: t = 32'h03FF_FFFF;
    endcase
    return (t << 6) | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nRST = 1'b0; pc = '0; upd_en = 1'b0; upd_pc = '0; upd_target = '0;
    upd_taken = 1'b0; upd_is_jump = 1'b0;
    repeat (2) @(posedge CLK);
    model_reset();
    #1;

    drive(1, 32'h100, 0, 0, 0, 0, 0, "rst_lookup");
    check("rst_hit_lit",  {31'd0, pred_hit},   32'd0);
    check("rst_pred_lit", pc_prediction,       32'h104);
    tick();
    drive(1, 32'h0, 1, 32'h100, 32'h200, 1, 0, "alloc"); tick();
    drive(1, 32'h100, 0, 0, 0, 0, 0, "alloc_look");
    check("alloc_taken_lit", {31'd0, pred_taken}, 32'd1);
    check("alloc_pred_lit",  pc_prediction,       32'h200);
    tick();
    drive(1, 32'h4, 1, 32'h100, 32'h200, 0, 0, "nt1"); tick();
    drive(1, 32'h4, 1, 32'h100, 32'h200, 0, 0, "nt2"); tick();
    drive(1, 32'h100, 0, 0, 0, 0, 0, "nt_look");
    check("nt_hit_lit",  {31'd0, pred_hit}, 32'd1);
    check("nt_pred_lit", pc_prediction,     32'h104);
    tick();
    drive(1, 32'h8, 1, 32'h100, 32'h200, 1, 0, "tk_once"); tick();
    drive(1, 32'h100, 0, 0, 0, 0, 0, "wnt_look");
    check("wnt_pred_lit", pc_prediction, 32'h104);
    tick();
    drive(1, 32'h8, 1, 32'h140, 32'h300, 1, 0, "alias_alloc"); tick();
    drive(1, 32'h100, 0, 0, 0, 0, 0, "alias_old");
    check("alias_old_pred_lit", pc_prediction, 32'h104);
    tick();
    drive(1, 32'h140, 0, 0, 0, 0, 0, "alias_new");
    check("alias_new_pred_lit", pc_prediction, 32'h300);
    tick();
    drive(0, 32'h8, 0, 0, 0, 0, 0, "rst2"); tick();
    drive(1, 32'h100, 1, 32'h100, 32'h200, 1, 0, "same_cyc");
    check("same_cyc_hit_lit", {31'd0, pred_hit}, 32'd0);
    tick();
    drive(1, 32'h100, 0, 0, 0, 0, 0, "same_next");
    check("same_next_hit_lit", {31'd0, pred_hit}, 32'd1);
    tick();
    drive(1, 32'h8, 1, 32'h080, 32'h010, 0, 1, "jump"); tick();
    drive(1, 32'h080, 0, 0, 0, 0, 0, "jump_look");
    check("jump_pred_lit", pc_prediction, 32'h010);
    tick();
    drive(0, 32'h080, 1, 32'h080, 32'h010, 1, 1, "rst_mid"); tick();
    drive(1, 32'h080, 0, 0, 0, 0, 0, "post_rst");
    check("post_rst_hit_lit",  {31'd0, pred_hit}, 32'd0);
    check("post_rst_pred_lit", pc_prediction,     32'h084);
    tick();
    drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, "wrap");
    check("wrap_pred_lit", pc_prediction, 32'h0);
    tick();

    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 99) != 0), rand_pc(), $urandom_range(0, 3) != 0,
            rand_pc(), $urandom, $urandom_range(0, 1), ($urandom_range(0, 5) == 0),
            "rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
